// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the boot-time program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    CSUM,
    RUN,
    ERR
  } state_e;

  localparam int unsigned HDR_LEN_BYTES  = 2;
  localparam int unsigned CSUM_LEN_BYTES = 1;

  function automatic logic [7:0] xor_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Gathers accepted bytes LSB-first into 32-bit words; flags the 4th byte of each word.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_en) begin
      shift_d = {byte_in, shift_q[31:8]};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Word is presented in the same cycle as its last byte so the write register captures it directly.
  assign word       = {byte_in, shift_q[31:8]};
  assign word_ready = byte_en & (cnt_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes words to instruction memory, releases the core on a good checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [16:0]       wcnt_q, wcnt_d;
  logic [7:0]        csum_q, csum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        accept;
  logic [16:0] n_full;
  logic [31:0] pk_word;
  logic        pk_ready;

  assign rx_ready = !restart &&
                    (state_q == LEN0 || state_q == LEN1 || state_q == DATA || state_q == CSUM);
  assign accept   = rx_valid && rx_ready;
  assign n_full   = {1'b0, rx_data, n_q[7:0]};

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (restart),
    .byte_en    (accept && state_q == DATA),
    .byte_in    (rx_data),
    .word       (pk_word),
    .word_ready (pk_ready)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (restart) begin
      state_d = LEN0;
      n_d     = '0;
      wcnt_d  = '0;
      csum_d  = '0;
    end else if (accept) begin
      if (state_q != CSUM) csum_d = xor_update(csum_q, rx_data);
      unique case (state_q)
        LEN0: begin
          n_d     = {8'h00, rx_data};
          state_d = LEN1;
        end
        LEN1: begin
          n_d = n_full[15:0];
          if (n_full > CAPACITY)   state_d = ERR;
          else if (n_full == '0)   state_d = CSUM;
          else                     state_d = DATA;
        end
        DATA: begin
          if (pk_ready) begin
            we_d    = 1'b1;
            addr_d  = wcnt_q[ADDR_W-1:0];
            wdata_d = pk_word;
            wcnt_d  = wcnt_q + 17'd1;
            if (wcnt_q + 17'd1 == {1'b0, n_q}) state_d = CSUM;
          end
        end
        CSUM:    state_d = (rx_data == csum_q) ? RUN : ERR;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LEN0;
      n_q     <= '0;
      wcnt_q  <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst_n = (state_q == RUN);
  assign load_done  = (state_q == RUN);
  assign load_err   = (state_q == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Table-driven frame loads with a write scoreboard, plus hand sequences for restart and reset.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              restart = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              load_done;
  logic              load_err;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] n;
    logic [7:0]  csum_flip;
    bit          gaps;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                due;
  } wr_t;

  wr_t         sb[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int          ncyc   = 0;
  logic [31:0] wtab [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest pending write and land on its due cycle.
  always @(negedge clk) begin
    wr_t e;
    ncyc++;
    if (rst_n && imem_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_write_addr", {24'h0, imem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("write_addr", {24'h0, imem_addr}, {24'h0, e.addr});
        chk("write_data", imem_wdata, e.data);
        chk("write_cycle", ncyc, e.due);
      end
    end else if (sb.size() != 0 && sb[0].due < ncyc) begin
      e = sb.pop_front();
      chk("missing_write", 32'h0, {24'h0, e.addr});
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps && $urandom_range(0, 1) == 1) begin
      rx_valid = 1'b0;
      repeat (5) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
    chk("rx_ready_loading", {31'h0, rx_ready}, 32'h1);
    @(posedge clk);
  endtask

  task automatic end_byte();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] n, input logic [7:0] flip, input bit gaps);
    logic [7:0] x;
    logic [7:0] b;
    logic [31:0] w;
    x = n[7:0] ^ n[15:8];
    send_byte(n[7:0], gaps);  end_byte();
    send_byte(n[15:8], gaps); end_byte();
    for (int unsigned i = 0; i < n; i++) begin
      w = wtab[i % 3];
      for (int unsigned k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        x = x ^ b;
        send_byte(b, gaps);
        if (k == 3) sb.push_back('{addr: ADDR_W'(i), data: w, due: ncyc + 1});
        end_byte();
      end
    end
    chk("core_held_before_csum", {31'h0, core_rst_n}, 32'h0);
    send_byte(x ^ flip, gaps);
    end_byte();
  endtask

  task automatic do_restart(input logic with_valid);
    restart  = 1'b1;
    rx_valid = with_valid;
    rx_data  = 8'h05;
    #1;
    chk("rx_ready_during_restart", {31'h0, rx_ready}, 32'h0);
    @(negedge clk);
    restart  = 1'b0;
    rx_valid = 1'b0;
    #1;
    chk("restart_core_rst_n", {31'h0, core_rst_n}, 32'h0);
    chk("restart_done", {31'h0, load_done}, 32'h0);
    chk("restart_err", {31'h0, load_err}, 32'h0);
    chk("restart_rx_ready", {31'h0, rx_ready}, 32'h1);
  endtask

  task automatic chk_status(input string name, input logic done, input logic err);
    #1;
    chk({name, "_done"}, {31'h0, load_done}, {31'h0, done});
    chk({name, "_err"}, {31'h0, load_err}, {31'h0, err});
    chk({name, "_core_rst_n"}, {31'h0, core_rst_n}, {31'h0, done});
    chk({name, "_rx_ready"}, {31'h0, rx_ready}, 32'h0);
  endtask

  initial begin
    vec_t vecs [6];
    wtab[0] = 32'h0050_0093;
    wtab[1] = 32'h00A0_0113;
    wtab[2] = 32'hDEAD_BEEF;
    vecs[0] = '{n: 16'd2, csum_flip: 8'h00, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{n: 16'd2, csum_flip: 8'h01, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[2] = '{n: 16'd0, csum_flip: 8'h00, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{n: 16'd0, csum_flip: 8'h01, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[4] = '{n: 16'd2, csum_flip: 8'h00, gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[5] = '{n: 16'd5, csum_flip: 8'h00, gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0};

    // Reset state.
    #2;
    chk("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    chk("rst_we", {31'h0, imem_we}, 32'h0);
    chk("rst_addr", {24'h0, imem_addr}, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_core_rst_n", {31'h0, core_rst_n}, 32'h0);
    chk("rst_done", {31'h0, load_done}, 32'h0);
    chk("rst_err", {31'h0, load_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (i > 0) do_restart(1'b0);
      send_frame(vecs[i].n, vecs[i].csum_flip, vecs[i].gaps);
      chk_status($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_err);
      @(negedge clk);
      chk_status($sformatf("vec%0d_hold", i), vecs[i].exp_done, vecs[i].exp_err);
      chk($sformatf("vec%0d_pending", i), sb.size(), 0);
    end

    // Oversize length: N = 0x0101 exceeds 256 words.
    do_restart(1'b0);
    send_byte(8'h01, 1'b0); end_byte();
    send_byte(8'h01, 1'b0); end_byte();
    chk_status("oversize", 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    // Restart with a valid byte present: it must not be consumed as LEN_LO.
    do_restart(1'b1);
    send_frame(16'd1, 8'h00, 1'b0);
    chk_status("restart_valid", 1'b1, 1'b0);
    chk("restart_valid_pending", sb.size(), 0);

    // Reset right after the 4th byte of a word: the pending write is dropped.
    do_restart(1'b0);
    send_byte(8'h02, 1'b0); end_byte();
    send_byte(8'h00, 1'b0); end_byte();
    send_byte(8'h93, 1'b0); end_byte();
    send_byte(8'h00, 1'b0); end_byte();
    send_byte(8'h50, 1'b0); end_byte();
    send_byte(8'h00, 1'b0);
    #1;
    chk("pre_reset_we", {31'h0, imem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_we", {31'h0, imem_we}, 32'h0);
    chk("async_addr", {24'h0, imem_addr}, 32'h0);
    chk("async_wdata", imem_wdata, 32'h0);
    chk("async_core_rst_n", {31'h0, core_rst_n}, 32'h0);
    chk("async_rx_ready", {31'h0, rx_ready}, 32'h1);
    end_byte();
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(16'd2, 8'h00, 1'b0);
    chk_status("after_reset", 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("final_pending", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader upstream of the single-cycle RISC-V core. It receives a framed byte stream over a valid/ready handshake, packs it into 32-bit little-endian words, and writes them sequentially from word address 0 into the instruction memory's write port. It holds the core in reset until a complete frame with a correct checksum has been loaded, then releases the core to run.

## Interface

- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.
- clk  in  1  clock; everything is rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- restart  in  1  synchronous single-cycle request to reload; valid in any state.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word to write.
- core_rst_n  out  1  active-low reset to the core; high only in state RUN.
- load_done  out  1  high in RUN.
- load_err  out  1  high in ERR.

## Operation

- Frame format:
  - LEN_LO byte, then LEN_HI byte, forming a 16-bit word count N.
  - 4·N data bytes, least-significant byte of each word first.
  - One CSUM byte.
- The checksum is the XOR of every byte preceding CSUM. The frame is good when CSUM equals that XOR.
- A byte is accepted when rx_valid & rx_ready.
- States:
  - LEN0: accept LEN_LO, then go to LEN1.
  - LEN1: accept LEN_HI, then:
    - N > 2^ADDR_W: go to ERR. The offending byte is accepted.
    - N = 0: go to CSUM.
    - Otherwise: go to DATA.
  - DATA: accept bytes. A 2-bit byte counter wraps 3→0. On every 4th byte, issue one word write and increment the word address. After the Nth word, go to CSUM.
  - CSUM: accept one byte. On match go to RUN, otherwise go to ERR.
  - RUN: rx_ready = 0. Hold until restart.
  - ERR: rx_ready = 0. Hold until restart.
- restart from any state:
  - Go to LEN0 on the next cycle.
  - Clear the word address, byte counter, running XOR and N.
  - rx_ready is forced to 0 while restart is high, so no byte is accepted that cycle.
- Memory contents are not cleared. Words beyond N keep their old values.
- Widths:
  - N is 16 bits; the word counter is 17 bits, so N = 2^ADDR_W is legal and exact.
  - imem_addr is the low ADDR_W bits of the word counter.
  - The running XOR is 8 bits.

## Timing

- Reset values:
  - State is LEN0.
  - rx_ready = 1, provided restart is low.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - core_rst_n = 0, load_done = 0, load_err = 0.
- rx_ready is a combinational function of the registered state and restart only. It never depends on rx_valid.
- rx_ready is 1 in LEN0, LEN1, DATA and CSUM.
- Write latency: imem_we, imem_addr and imem_wdata are registered. They are valid for exactly one cycle, starting the cycle after the 4th byte of a word is accepted.
- Back-to-back bytes every cycle are sustained at full throughput with no stall.
- Release latency: core_rst_n rises and load_done rises in the cycle after a matching CSUM byte is accepted.
- Error latency: load_err rises in the cycle after the offending LEN_HI byte or the mismatched CSUM byte is accepted.
- On restart, core_rst_n falls, and load_done and load_err clear, on the next cycle.
- Asynchronous reset mid-frame: return to the reset values immediately. A pending imem_we is cancelled.
- rx_valid low in mid-word: bytes already gathered are held indefinitely. Nothing times out.

## Structure

- Package prog_loader_pkg contains:
  - State enum: LEN0, LEN1, DATA, CSUM, RUN, ERR.
  - Header length constant (2 bytes) and CSUM length constant (1 byte).
  - The function computing the XOR update.
- One natural sub-module, byte_packer:
  - Shifts accepted bytes into a 32-bit register, LSB first.
  - Owns the 2-bit byte counter.
  - Asserts word_ready when the 4th byte arrives.
- The top level owns the FSM, the word counter, the checksum, and the output registers.

## Test plan

- Load N=2 with words 0x00500093 and 0x00A00113, bytes 02 00 93 00 50 00 13 01 A0 00, and CSUM = XOR of those bytes → expect:
  - Writes at addresses 0 and 1 with exactly those values.
  - core_rst_n high one cycle after CSUM.
- Same frame with CSUM XOR 0x01 → expect load_err=1, core_rst_n held low, and no further rx_ready.
- ADDR_W=8, LEN = 0x0101 → expect ERR the cycle after LEN_HI and no imem_we.
- N=0 with CSUM=0x00 → expect RUN with no writes. With CSUM=0x01 → expect ERR.
- Drop rx_valid for 5 cycles between every byte, at random points → expect writes identical to the back-to-back run, each one cycle after its 4th byte.
- Check restart and reset behaviour:
  - Assert restart while in RUN → expect core_rst_n low next cycle and a fresh frame loaded from address 0.
  - Assert restart together with rx_valid → expect that byte not consumed.
  - Pull rst_n low mid-word → expect outputs at their reset values immediately.
